// File: rtl/am_fifo_stage_if.sv
// Handshake and status bundle between a producer/controller and am_fifo_stage.
interface am_fifo_stage_if #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] din;
   logic             si;
   logic             ir;
   logic [WIDTH-1:0] dout;
   logic             so;
   logic             orr;
   logic [AW:0]      count;
   logic             err;

   // Producer / microcode controller side
   modport master (
      output din, si, so,
      input  ir, dout, orr, count, err
   );

   // FIFO side
   modport slave (
      input  din, si, so,
      output ir, dout, orr, count, err
   );
endinterface

// File: rtl/am_fifo_stage.sv
// First-word-fall-through FIFO feeding an am2954-style output register.
// The head word is always visible on dout; the controller retires it with so.
module am_fifo_stage #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input logic              cp,
   input logic              clr,
   am_fifo_stage_if.slave   bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wp_q;
   logic [AW-1:0]    rp_q;
   logic [AW:0]      count_q;
   logic             err_q;

   logic             ir_c;
   logic             orr_c;
   logic             wr_en_c;
   logic             rd_en_c;
   logic             reject_c;

   // Ready flags decoded from registered occupancy only
   always_comb begin
      ir_c     = (count_q != CW'(DEPTH));
      orr_c    = (count_q != '0);
      wr_en_c  = bus.si & ir_c;
      rd_en_c  = bus.so & orr_c;
      reject_c = (bus.si & ~ir_c) | (bus.so & ~orr_c);
   end

   // Storage, pointers, occupancy and sticky error; clr wipes everything
   always_ff @(posedge cp) begin
      if (clr) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wp_q    <= '0;
         rp_q    <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (wr_en_c) begin
            mem_q[wp_q] <= bus.din;
            wp_q        <= wp_q + AW'(1);
         end
         if (rd_en_c) begin
            rp_q <= rp_q + AW'(1);
         end
         case ({wr_en_c, rd_en_c})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
         if (reject_c) begin
            err_q <= 1'b1;
         end
      end
   end

   // Head word presented continuously; zero while empty
   always_comb begin
      bus.dout  = orr_c ? mem_q[rp_q] : '0;
      bus.ir    = ir_c;
      bus.orr   = orr_c;
      bus.count = count_q;
      bus.err   = err_q;
   end
endmodule

// File: tb/tb_am_fifo_stage.sv
// Directed self-checking bench for am_fifo_stage (WIDTH=8, DEPTH=4).
module tb_am_fifo_stage;
   logic cp;
   logic clr;
   int   checks;
   int   errors;

   am_fifo_stage_if #(.WIDTH(8), .DEPTH(4)) bus ();

   am_fifo_stage #(.WIDTH(8), .DEPTH(4)) dut (
      .cp  (cp),
      .clr (clr),
      .bus (bus)
   );

   initial cp = 1'b0;
   always #5 cp = ~cp;

   typedef struct {
      logic       clr;
      logic       si;
      logic       so;
      logic [7:0] din;
      logic [2:0] count;
      logic       ir;
      logic       orr;
      logic [7:0] dout;
      logic       err;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic c, input logic s_in, input logic s_out, input logic [7:0] d);
      @(negedge cp);
      clr     = c;
      bus.si  = s_in;
      bus.so  = s_out;
      bus.din = d;
      @(posedge cp);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [2:0] c, input logic r_in,
                            input logic r_out, input logic [7:0] d, input logic e);
      check({tag, ".count"}, 32'(bus.count), 32'(c));
      check({tag, ".ir"},    32'(bus.ir),    32'(r_in));
      check({tag, ".orr"},   32'(bus.orr),   32'(r_out));
      check({tag, ".dout"},  32'(bus.dout),  32'(d));
      check({tag, ".err"},   32'(bus.err),   32'(e));
   endtask

   initial begin
      logic [7:0] exp_word;
      checks  = 0;
      errors  = 0;
      clr     = 1'b1;
      bus.si  = 1'b0;
      bus.so  = 1'b0;
      bus.din = 8'h00;

      //              clr   si    so    din    cnt   ir    orr   dout   err
      vecs.push_back('{1'b1, 1'b1, 1'b1, 8'hFF, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0}); // reset, strobes ignored
      vecs.push_back('{1'b1, 1'b1, 1'b1, 8'hFF, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h11, 3'd1, 1'b1, 1'b1, 8'h11, 1'b0}); // fill
      vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h22, 3'd2, 1'b1, 1'b1, 8'h11, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h33, 3'd3, 1'b1, 1'b1, 8'h11, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h44, 3'd4, 1'b0, 1'b1, 8'h11, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h55, 3'd4, 1'b0, 1'b1, 8'h11, 1'b1}); // overflow
      vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 3'd3, 1'b1, 1'b1, 8'h22, 1'b1}); // drain, err sticky
      vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 3'd2, 1'b1, 1'b1, 8'h33, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 3'd1, 1'b1, 1'b1, 8'h44, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0}); // clr clears err
      vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1}); // underflow
      vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h10, 3'd1, 1'b1, 1'b1, 8'h10, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h20, 3'd2, 1'b1, 1'b1, 8'h10, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 8'hA5, 3'd2, 1'b1, 1'b1, 8'h20, 1'b0}); // sim at count=2
      vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 3'd1, 1'b1, 1'b1, 8'hA5, 1'b0});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h3C, 3'd1, 1'b1, 1'b1, 8'h3C, 1'b1}); // sim at empty
      vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h5A, 3'd2, 1'b1, 1'b1, 8'h3C, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h01, 3'd3, 1'b1, 1'b1, 8'h3C, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 1'b0, 8'h02, 3'd4, 1'b0, 1'b1, 8'h3C, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 1'b1, 8'h99, 3'd3, 1'b1, 1'b1, 8'h5A, 1'b1}); // sim at full
      vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 3'd2, 1'b1, 1'b1, 8'h01, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 3'd1, 1'b1, 1'b1, 8'h02, 1'b1});
      vecs.push_back('{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0});

      foreach (vecs[i]) begin
         drive(vecs[i].clr, vecs[i].si, vecs[i].so, vecs[i].din);
         check_all($sformatf("vec%0d", i), vecs[i].count, vecs[i].ir, vecs[i].orr,
                   vecs[i].dout, vecs[i].err);
      end

      // Streaming with pointer wrap: prefill two, then one read per write
      drive(1'b0, 1'b1, 1'b0, 8'h01);
      drive(1'b0, 1'b1, 1'b0, 8'h02);
      check_all("prefill", 3'd2, 1'b1, 1'b1, 8'h01, 1'b0);
      exp_word = 8'h01;
      for (int k = 3; k <= 10; k++) begin
         check($sformatf("stream_head%0d", k), 32'(bus.dout), 32'(exp_word));
         drive(1'b0, 1'b1, 1'b1, 8'(k));
         exp_word = exp_word + 8'h01;
         check($sformatf("stream_cnt%0d", k), 32'(bus.count), 32'd2);
      end
      for (int k = 0; k < 2; k++) begin
         check($sformatf("tail_head%0d", k), 32'(bus.dout), 32'(exp_word));
         drive(1'b0, 1'b0, 1'b1, 8'h00);
         exp_word = exp_word + 8'h01;
      end
      check_all("stream_end", 3'd0, 1'b1, 1'b0, 8'h00, 1'b0);

      // Reset in the middle of a burst with strobes held high
      drive(1'b0, 1'b1, 1'b0, 8'hE1);
      drive(1'b0, 1'b1, 1'b0, 8'hE2);
      drive(1'b0, 1'b1, 1'b0, 8'hE3);
      check_all("pre_clr", 3'd3, 1'b1, 1'b1, 8'hE1, 1'b0);
      drive(1'b1, 1'b1, 1'b1, 8'hEE);
      check_all("mid_clr", 3'd0, 1'b1, 1'b0, 8'h00, 1'b0);
      drive(1'b0, 1'b1, 1'b0, 8'h77);
      check_all("post_clr", 3'd1, 1'b1, 1'b1, 8'h77, 1'b0);
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      check_all("idle", 3'd1, 1'b1, 1'b1, 8'h77, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/am_fifo_stage.md
# am_fifo_stage

Parameterised first-word-fall-through FIFO that sits directly upstream of an am2954-style tristate output register. It absorbs bursts from a producer with a shift-in handshake and presents the oldest word continuously on its output. The downstream register then captures that word on its own clock edge, and the controller pulses the shift-out strobe to retire it. All state is synchronous to one clock; occupancy and sticky error status are exported for the microcode controller.

## Interface

Parameters:
- WIDTH, 8, data word width (matches am2954 WIDTH).
- DEPTH, 4, number of storage words; power of two, 2..16.
- AW, log2(DEPTH) (2 for default), pointer width; derived, not overridden.

Ports:
- cp  input  1  clock; all state changes on rising edge.
- clr  input  1  synchronous reset, active-high; sampled on rising edge of cp.
- din  input  WIDTH  write data.
- si  input  1  shift-in strobe; write din this edge if ir=1.
- ir  output  1  input ready = not full.
- dout  output  WIDTH  oldest stored word (head); feeds am2954 d.
- so  input  1  shift-out strobe; retire head this edge if orr=1.
- orr  output  1  output ready = not empty.
- count  output  AW+1  number of stored words, 0..DEPTH.
- err  output  1  sticky: set on write while full or read while empty.

## Operation

- Storage: DEPTH×WIDTH array, write pointer wp, read pointer rp, each AW bits, plus count register (AW+1 bits).
- Pointers wrap modulo DEPTH: DEPTH-1 increments to 0.
- Write accepted = si & ir. On acceptance: mem[wp] <= din, wp <= wp+1.
- Read accepted = so & orr. On acceptance: rp <= rp+1.
- count update per edge:
  - +1 on write only.
  - -1 on read only.
  - unchanged on both or neither.
- ir = (count != DEPTH); orr = (count != 0). Both are decoded from registered count, no combinational path from si/so.
- dout = mem[rp] when orr=1; dout = 0 when orr=0. This is combinational from registers only.
- Simultaneous si and so:
  - 0 < count < DEPTH: both accepted; count unchanged; new word is not visible at head unless count was 1.
  - count = DEPTH (full): read accepted, write rejected. No pass-through; the producer must retry.
  - count = 0 (empty): write accepted, read rejected. Word appears on dout next cycle.
- Rejected strobes leave data, pointers and count untouched and set err <= 1.
- err holds at 1 until clr; no other clear path.
- clr has priority over si/so on the same edge. On clr:
  - wp = rp = 0, count = 0, err = 0.
  - every mem word = 0.
  - Any in-flight strobe on that edge is discarded.

## Timing

- Reset values after the clr edge: ir=1, orr=0, count=0, err=0, dout=0.
- Write latency: a word accepted at edge N is on dout after edge N when it is the head (FIFO was empty). orr rises after edge N.
- Read: head retired at edge M. The next word, or 0 if now empty, is on dout after edge M.
- Full flag: ir falls after the edge that makes count=DEPTH. It rises after the first accepted read.
- err rises after the offending edge, not combinationally.
- Back-to-back strobes every cycle are supported: sustained throughput is one word per cycle in and out.
- clr asserted mid-burst: the state shown above holds from the next cycle. Strobes held high through clr take effect on the first edge after clr deasserts.

## Test plan

- Reset: hold clr 2 cycles with si=so=1, din=8'hFF. Expect count=0, ir=1, orr=0, dout=8'h00, err=0.
- Fill and drain order: write 8'h11, 8'h22, 8'h33, 8'h44 on 4 edges. Expect count=4, ir=0, dout=8'h11. Then pulse so 4 times. Expect dout sequence 8'h22, 8'h33, 8'h44, 8'h00; orr=0; err=0.
- Overflow: after filling, assert si with din=8'h55 for one edge. Expect count stays 4, contents unchanged, err=1 and sticky through a following drain.
- Underflow: from empty, pulse so. Expect count=0, err=1.
- Simultaneous access:
  - count=2, si=so=1 with din=8'hA5: count stays 2, head advances.
  - count=0, si=so=1 with din=8'h3C: count=1, dout=8'h3C.
  - count=4, si=so=1: count=3, err=1.
- Wrap-around and mid-burst reset:
  - Stream 10 words 8'h01..8'h0A, one read per write after 2-word prefill. Output order must be 01..0A with no loss.
  - Assert clr while count=3. Expect empty state next cycle, then a fresh write of 8'h77 appears on dout.
